// File: rtl/mod_exp_ctrl_if.sv
// Host and mon_prod handshake bundle for the modular-exponentiation sequencer.
// The master side drives start/exponent/exp_len and mp_stop; the slave side is the sequencer.
interface mod_exp_ctrl_if #(
  parameter int EBITS = 1024,
  parameter int LBITS = 11
);
  logic             start;
  logic [EBITS-1:0] exponent;
  logic [LBITS-1:0] exp_len;
  logic             busy;
  logic             done;
  logic             error;
  logic [11:0]      op_count;
  logic [LBITS-1:0] bit_idx;
  logic             mp_start;
  logic [1:0]       mp_op_code;
  logic             mp_stop;

  modport master (
    output start, exponent, exp_len, mp_stop,
    input  busy, done, error, op_count, bit_idx, mp_start, mp_op_code
  );

  modport slave (
    input  start, exponent, exp_len, mp_stop,
    output busy, done, error, op_count, bit_idx, mp_start, mp_op_code
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mon_prod through start/op_code/stop.
// Each op is complete on a rising edge of mp_stop; a per-op watchdog aborts a stalled run.
module mod_exp_ctrl #(
  parameter int EBITS   = 1024,
  parameter int LBITS   = 11,
  parameter int TBITS   = 12,
  parameter int TIMEOUT = 2048
) (
  input  logic          clk,
  input  logic          rst,
  mod_exp_ctrl_if.slave bus
);
  localparam int IBITS = (EBITS > 1) ? $clog2(EBITS) : 1;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] SQ_ISSUE   = 4'd1;
  localparam logic [3:0] SQ_WAIT    = 4'd2;
  localparam logic [3:0] MUL_ISSUE  = 4'd3;
  localparam logic [3:0] MUL_WAIT   = 4'd4;
  localparam logic [3:0] NEXT       = 4'd5;
  localparam logic [3:0] CONV_ISSUE = 4'd6;
  localparam logic [3:0] CONV_WAIT  = 4'd7;
  localparam logic [3:0] DONE       = 4'd8;

  localparam logic [LBITS-1:0] EBITS_L = LBITS'(EBITS);
  localparam logic [TBITS-1:0] WD_LAST = TBITS'(TIMEOUT - 1);

  logic [3:0]       state_reg;
  logic [EBITS-1:0] exp_reg;
  logic [TBITS-1:0] wd_reg;
  logic             stop_q_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;
  logic             mp_start_reg;
  logic [1:0]       op_code_reg;
  logic [11:0]      op_count_reg;
  logic [LBITS-1:0] bit_idx_reg;

  logic [LBITS-1:0] len_clamped;
  logic             completion;
  logic             cur_bit;
  logic             wd_expired;

  assign len_clamped = (bus.exp_len > EBITS_L) ? EBITS_L : bus.exp_len;
  // Edge detect rather than level so a stale or X stop after reset never completes an op.
  assign completion  = bus.mp_stop & ~stop_q_reg;
  assign cur_bit     = exp_reg[bit_idx_reg[IBITS-1:0]];
  assign wd_expired  = (wd_reg == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      exp_reg      <= '0;
      wd_reg       <= '0;
      stop_q_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      mp_start_reg <= 1'b0;
      op_code_reg  <= OPXX;
      op_count_reg <= '0;
      bit_idx_reg  <= '0;
    end else begin
      stop_q_reg   <= bus.mp_stop;
      mp_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            exp_reg      <= bus.exponent;
            error_reg    <= 1'b0;
            op_count_reg <= '0;
            busy_reg     <= 1'b1;
            if (len_clamped == '0) begin
              state_reg <= CONV_ISSUE;
            end else begin
              bit_idx_reg <= len_clamped - 1'b1;
              state_reg   <= SQ_ISSUE;
            end
          end
        end
        SQ_ISSUE: begin
          mp_start_reg <= 1'b1;
          op_code_reg  <= OPXX;
          op_count_reg <= op_count_reg + 12'd1;
          wd_reg       <= '0;
          state_reg    <= SQ_WAIT;
        end
        MUL_ISSUE: begin
          mp_start_reg <= 1'b1;
          op_code_reg  <= OPXM;
          op_count_reg <= op_count_reg + 12'd1;
          wd_reg       <= '0;
          state_reg    <= MUL_WAIT;
        end
        CONV_ISSUE: begin
          mp_start_reg <= 1'b1;
          op_code_reg  <= OPX1;
          op_count_reg <= op_count_reg + 12'd1;
          wd_reg       <= '0;
          state_reg    <= CONV_WAIT;
        end
        SQ_WAIT, MUL_WAIT, CONV_WAIT: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (completion) begin
            if (state_reg == SQ_WAIT)
              state_reg <= cur_bit ? MUL_ISSUE : NEXT;
            else if (state_reg == MUL_WAIT)
              state_reg <= NEXT;
            else
              state_reg <= DONE;
          end else if (wd_expired) begin
            error_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        NEXT: begin
          if (bit_idx_reg == '0) begin
            state_reg <= CONV_ISSUE;
          end else begin
            bit_idx_reg <= bit_idx_reg - 1'b1;
            state_reg   <= SQ_ISSUE;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.error      = error_reg;
  assign bus.op_count   = op_count_reg;
  assign bus.bit_idx    = bit_idx_reg;
  assign bus.mp_start   = mp_start_reg;
  assign bus.mp_op_code = op_code_reg;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a mon_prod stub that answers each op 20 cycles later.
// Op codes are logged at every mp_start and compared against hand-derived sequences.
module tb_mod_exp_ctrl;
  localparam int EBITS = 1024;
  localparam int LBITS = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_exp_ctrl_if #(.EBITS(EBITS), .LBITS(LBITS)) bus ();

  mod_exp_ctrl #(
    .EBITS(EBITS), .LBITS(LBITS), .TBITS(12), .TIMEOUT(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int op_seen  = 0;
  int log_q[$];
  int hang_op  = -1;
  int stub_cnt = 0;

  // mon_prod stub: stop drops after each mp_start and rises 20 cycles later unless told to hang.
  initial begin
    bus.mp_stop = 1'b1;
    forever begin
      @(negedge clk);
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) bus.mp_stop = 1'b1;
      end
      if (bus.mp_start === 1'b1) begin
        op_seen++;
        log_q.push_back(int'(bus.mp_op_code));
        $display("op %0d: mp_op_code=%0d op_count=%0d bit_idx=%0d",
                 op_seen, bus.mp_op_code, bus.op_count, bus.bit_idx);
        bus.mp_stop = 1'b0;
        stub_cnt = (op_seen == hang_op) ? 0 : 20;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_run(input logic [EBITS-1:0] e, input int len);
    @(negedge clk);
    bus.exponent = e;
    bus.exp_len  = LBITS'(len);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound, output int dones);
    int cyc;
    cyc   = 0;
    dones = 0;
    while (bus.busy === 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) dones++;
    end
    check({tag, "_in_time"}, 32'(cyc < bound), 32'd1);
    @(negedge clk);
    if (bus.done === 1'b1) dones++;
    $display("%s: idle after %0d cycles, done pulses %0d, op_count %0d, error %0d",
             tag, cyc, dones, bus.op_count, bus.error);
  endtask

  task automatic wait_ops(input string tag, input int n, input int bound);
    int cyc;
    cyc = 0;
    while (log_q.size() < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ops_in_time"}, 32'(cyc < bound), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     32'(bus.busy),       32'd0);
    check({tag, "_done"},     32'(bus.done),       32'd0);
    check({tag, "_error"},    32'(bus.error),      32'd0);
    check({tag, "_mp_start"}, 32'(bus.mp_start),   32'd0);
    check({tag, "_op_code"},  32'(bus.mp_op_code), 32'd0);
    check({tag, "_op_count"}, 32'(bus.op_count),   32'd0);
    check({tag, "_bit_idx"},  32'(bus.bit_idx),    32'd0);
  endtask

  initial begin
    int base;
    int d;
    int seq_1011[8];
    int seq_10[4];
    seq_1011 = '{0, 1, 0, 0, 1, 0, 1, 2};
    seq_10   = '{0, 1, 0, 2};

    bus.start    = 1'b0;
    bus.exponent = '0;
    bus.exp_len  = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stale_stop_no_op", 32'(log_q.size()), 32'd0);

    // exponent 1011, four bits: squares and multiplies in left-to-right order
    base = log_q.size();
    start_run(EBITS'(4'b1011), 4);
    check("lat_issue_cycle_mp_start", 32'(bus.mp_start), 32'd0);
    @(negedge clk);
    check("lat_first_mp_start", 32'(bus.mp_start), 32'd1);
    check("first_op_code", 32'(bus.mp_op_code), 32'd0);
    wait_idle("e1011", 1000, d);
    check("e1011_done_pulses", 32'(d), 32'd1);
    check("e1011_error", 32'(bus.error), 32'd0);
    check("e1011_busy", 32'(bus.busy), 32'd0);
    check("e1011_op_count", 32'(bus.op_count), 32'd8);
    check("e1011_ops_seen", 32'(log_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("e1011_seq%0d", i), 32'(log_q[base + i]), 32'(seq_1011[i]));

    // zero-length exponent: conversion only
    base = log_q.size();
    start_run(EBITS'(4'b1011), 0);
    wait_idle("len0", 200, d);
    check("len0_done_pulses", 32'(d), 32'd1);
    check("len0_op_count", 32'(bus.op_count), 32'd1);
    check("len0_ops_seen", 32'(log_q.size() - base), 32'd1);
    check("len0_op_code", 32'(log_q[base]), 32'd2);

    // all-ones exponent with exp_len past EBITS is clamped to 1024 bits
    base = log_q.size();
    start_run('1, 1100);
    wait_idle("clamp", 60000, d);
    check("clamp_done_pulses", 32'(d), 32'd1);
    check("clamp_error", 32'(bus.error), 32'd0);
    check("clamp_op_count", 32'(bus.op_count), 32'd2049);
    check("clamp_ops_seen", 32'(log_q.size() - base), 32'd2049);
    check("clamp_first_op", 32'(log_q[base]), 32'd0);
    check("clamp_second_op", 32'(log_q[base + 1]), 32'd1);
    check("clamp_last_op", 32'(log_q[log_q.size() - 1]), 32'd2);
    check("clamp_bit_idx", 32'(bus.bit_idx), 32'd0);

    // stub hangs on the third op: watchdog aborts the run
    base    = log_q.size();
    hang_op = op_seen + 3;
    start_run(EBITS'(4'b1011), 4);
    wait_idle("wdog", 3000, d);
    check("wdog_error", 32'(bus.error), 32'd1);
    check("wdog_done_pulses", 32'(d), 32'd1);
    check("wdog_op_count", 32'(bus.op_count), 32'd3);
    check("wdog_ops_seen", 32'(log_q.size() - base), 32'd3);
    repeat (40) @(negedge clk);
    check("wdog_no_more_ops", 32'(log_q.size() - base), 32'd3);
    check("wdog_error_held", 32'(bus.error), 32'd1);

    // a new start clears the error
    hang_op = -1;
    base    = log_q.size();
    start_run(EBITS'(4'b1011), 4);
    check("clear_error_on_start", 32'(bus.error), 32'd0);
    wait_idle("clear", 1000, d);
    check("clear_error_after", 32'(bus.error), 32'd0);
    check("clear_op_count", 32'(bus.op_count), 32'd8);

    // stop is high from the last run; reset, then pulse start during SQ_WAIT
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    base = log_q.size();
    check("stuck_stop_idle_busy", 32'(bus.busy), 32'd0);
    start_run(EBITS'(4'b1011), 4);
    wait_ops("sqwait", base + 1, 50);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("sqwait_still_first_op", 32'(bus.op_count), 32'd1);
    check("sqwait_ops_seen_early", 32'(log_q.size() - base), 32'd1);
    wait_idle("sqwait", 1000, d);
    check("sqwait_done_pulses", 32'(d), 32'd1);
    check("sqwait_op_count", 32'(bus.op_count), 32'd8);
    check("sqwait_ops_seen", 32'(log_q.size() - base), 32'd8);

    // asynchronous reset in MUL_WAIT, then exponent 10
    base = log_q.size();
    start_run(EBITS'(4'b1011), 4);
    wait_ops("midrst", base + 2, 200);
    repeat (5) @(negedge clk);
    check("midrst_in_mul_wait", 32'(bus.mp_op_code), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    base = log_q.size();
    start_run(EBITS'(2'b10), 2);
    wait_idle("e10", 500, d);
    check("e10_done_pulses", 32'(d), 32'd1);
    check("e10_op_count", 32'(bus.op_count), 32'd4);
    check("e10_ops_seen", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("e10_seq%0d", i), 32'(log_q[base + i]), 32'(seq_10[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
